// File: rtl/verilog_reduce_pipe.sv
// Pipelined multi-operand reduction unit with per-packet accumulation.
// Stage 1 reduces one beat; stage 2 folds beats and loads the output register on the last beat.
module verilog_reduce_pipe #(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [2:0]              in_mode,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_flag,
   output logic                    out_err,
   output logic [CNT_W-1:0]        out_beats
);

   localparam logic [2:0] MODE_AND  = 3'd0;
   localparam logic [2:0] MODE_OR   = 3'd1;
   localparam logic [2:0] MODE_XOR  = 3'd2;
   localparam logic [2:0] MODE_LAND = 3'd3;
   localparam logic [2:0] MODE_LOR  = 3'd4;

   typedef enum logic {ACC_IDLE, ACC_BUSY} acc_state_t;

   logic en;
   logic in_acc;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign in_acc   = in_valid && en;

   // Input-side packet tracking so later beats reduce with the first beat's mode
   logic       in_pkt;
   logic [2:0] mode_lat;
   logic [2:0] eff_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_pkt   <= 1'b0;
         mode_lat <= 3'd0;
      end else if (in_acc) begin
         in_pkt <= !in_last;
         if (!in_pkt) mode_lat <= in_mode;
      end
   end

   assign eff_mode = in_pkt ? mode_lat : in_mode;

   logic [WIDTH-1:0] red_and;
   logic [WIDTH-1:0] red_or;
   logic [WIDTH-1:0] red_xor;
   logic [WIDTH-1:0] beat_red;
   logic             all_nz;
   logic             any_nz;

   always_comb begin
      red_and  = '1;
      red_or   = '0;
      red_xor  = '0;
      all_nz   = 1'b1;
      any_nz   = 1'b0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         red_and = red_and & in_data[k*WIDTH +: WIDTH];
         red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
         red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
         all_nz  = all_nz & (|in_data[k*WIDTH +: WIDTH]);
         any_nz  = any_nz | (|in_data[k*WIDTH +: WIDTH]);
      end
      beat_red = red_or;
      case (eff_mode)
         MODE_AND:  beat_red = red_and;
         MODE_OR:   beat_red = red_or;
         MODE_XOR:  beat_red = red_xor;
         MODE_LAND: beat_red = WIDTH'(all_nz);
         MODE_LOR:  beat_red = WIDTH'(any_nz);
         default:   beat_red = red_or;
      endcase
   end

   logic             s1_valid;
   logic [WIDTH-1:0] s1_red;
   logic             s1_last;
   logic [2:0]       s1_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_red   <= '0;
         s1_last  <= 1'b0;
         s1_mode  <= 3'd0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_red  <= beat_red;
            s1_last <= in_last;
            s1_mode <= eff_mode;
         end
      end
   end

   acc_state_t       acc_state;
   acc_state_t       acc_state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [CNT_W-1:0] acc_beats;
   logic [CNT_W-1:0] beats_nxt;
   logic             acc_err;
   logic             err_nxt;
   logic [WIDTH-1:0] combined;
   logic [WIDTH-1:0] merged;
   logic [CNT_W-1:0] beats_inc;
   logic             err_cur;
   logic             first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_state <= ACC_IDLE;
         acc       <= '0;
         acc_beats <= '0;
         acc_err   <= 1'b0;
      end else begin
         acc_state <= acc_state_nxt;
         acc       <= acc_nxt;
         acc_beats <= beats_nxt;
         acc_err   <= err_nxt;
      end
   end

   // Fold the stage-1 beat into the running result; logical modes fold their per-beat bit
   always_comb begin
      acc_state_nxt = acc_state;
      acc_nxt       = acc;
      beats_nxt     = acc_beats;
      err_nxt       = acc_err;
      first         = (acc_state == ACC_IDLE);
      combined      = acc | s1_red;
      case (s1_mode)
         MODE_AND, MODE_LAND: combined = acc & s1_red;
         MODE_XOR:            combined = acc ^ s1_red;
         default:             combined = acc | s1_red;
      endcase
      merged    = first ? s1_red : combined;
      beats_inc = first ? CNT_W'(1)
                        : ((acc_beats == '1) ? acc_beats : acc_beats + CNT_W'(1));
      err_cur   = first ? (s1_mode > MODE_LOR) : acc_err;
      if (en && s1_valid) begin
         if (s1_last) begin
            acc_state_nxt = ACC_IDLE;
         end else begin
            acc_state_nxt = ACC_BUSY;
            acc_nxt       = merged;
            beats_nxt     = beats_inc;
            err_nxt       = err_cur;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_flag  <= 1'b0;
         out_err   <= 1'b0;
         out_beats <= '0;
      end else if (en) begin
         if (s1_valid && s1_last) begin
            out_valid <= 1'b1;
            out_data  <= merged;
            out_flag  <= |merged;
            out_err   <= err_cur;
            out_beats <= beats_inc;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/verilog_reduce_pipe.md
Name: verilog_reduce_pipe

Overview:
- Parametrised, pipelined reduction unit: combines NUM_IN operands of WIDTH bits per beat using a selectable AND/OR/XOR/logical-AND/logical-OR operator.
- Accumulates the result across multi-beat packets delimited by in_last.
- Emits one result per packet on a valid/ready output.
- Used wherever wide multi-source condition or flag reductions must be registered and back-pressured rather than computed in a flat combinational cone.

Parameters:
- NUM_IN, 4, number of operands per beat (>=2).
- WIDTH, 1, bits per operand (>=1).
- CNT_W, 8, width of the saturating beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  NUM_IN*WIDTH  operands; operand k = in_data[k*WIDTH +: WIDTH].
- in_mode  in  3  0=bitwise AND, 1=bitwise OR, 2=bitwise XOR, 3=logical AND, 4=logical OR, 5-7 reserved.
- in_last  in  1  final beat of packet.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  WIDTH  reduced result; logical modes give {WIDTH-1 zeros, result bit}.
- out_flag  out  1  |out_data.
- out_err  out  1  packet used a reserved mode.
- out_beats  out  CNT_W  beats in packet, saturating at 2^CNT_W-1.

Behaviour:
- Reset (async assert, sync release): all valids 0, accumulator idle, out_data 0, out_flag 0, out_err 0, out_beats 0. A packet in flight is discarded.
- Global enable: en = !out_valid || out_ready. in_ready = en. All pipeline registers advance only when en = 1.
- Stage 1 (registered): reduces one beat's NUM_IN operands.
  - AND/OR/XOR: bitwise across operands.
  - Logical AND: 1 if every operand != 0.
  - Logical OR: 1 if any operand != 0.
  - Captures s1_valid, s1_red, s1_last, s1_mode.
- Mode latching: mode is sampled on the first beat of a packet (the accumulator is idle). Mode values on later beats are ignored.
- Reserved modes: treated as bitwise OR; out_err = 1 for that packet.
- Stage 2 (accumulator):
  - First beat: acc = s1_red, beats = 1.
  - Subsequent beats: acc = acc OP s1_red, using the latched mode (XOR accumulates XOR; logical AND ANDs the per-beat bits).
  - beats increments, saturating.
  - When s1_last, the result moves to the output register: out_valid = 1 and the accumulator returns to idle in the same cycle.
- Latency: the last beat accepted at cycle T gives out_valid at T+2 (no stall).
- Throughput: one beat per cycle. Single-beat packets may issue back-to-back, one result per cycle.
- Stall: out_valid && !out_ready freezes both stages. in_ready = 0. Outputs hold stable.
- Simultaneous consume and new result: when out_ready is high with out_valid, the next result loads in the same cycle with no bubble.
- Single-beat packet (in_last on the first beat) is legal. out_beats = 1.
- Beat-counter saturation: the counter holds at its maximum value. Accumulation continues correctly.

Test Plan:
- NUM_IN=4, WIDTH=1, mode 0, single beat in_data=4'b1111, last=1 -> out_valid 2 cycles later, out_data=1, out_flag=1, out_beats=1, out_err=0. Then 4'b1011 -> out_data=0.
- WIDTH=8, mode 2, two-beat packet {8'h0F,8'hF0,8'h00,8'h01} then {8'hFF,8'h00,8'h00,8'h00}, mode changed to 0 on beat 2 -> out_data=8'h01 (XOR kept), out_beats=2.
- WIDTH=8, mode 3, beats {1,2,3,4} then {5,0,6,7} -> out_data=8'h00, out_flag=0. Same stimulus with mode 4 -> out_data=8'h01.
- out_ready held 0 for 5 cycles with a result pending and 3 packets offered -> in_ready=0 throughout, out_* stable. Releasing out_ready delivers all 3 results on consecutive cycles, no loss or duplication.
- mode 6 single beat {0,0,2'b01,0}, WIDTH=2 -> out_data=2'b01, out_err=1. Next packet mode 1 -> out_err=0.
- CNT_W=2, 5-beat mode 1 packet -> out_beats=3 (saturated). Assert rst_n=0 mid-packet -> out_valid drops immediately; after release, a fresh packet produces the correct result with out_beats starting at 1.
